// File: rtl/mc_control_fsm_v2.sv
// ----------------------------------------------------------------------------
// mc_control_fsm_v2
//
// Multi-cycle MIPS control FSM for the MCI core. It drives the datapath
// control nets from the current state and the RAM handshake.
//
// Behaviour beyond the original fixed-timing controller:
//   - Variable-latency memory: FETCH, MEMRD and MEMWR stall until mem_ready.
//   - Memory timeout watchdog: too many consecutive not-ready cycles in one
//     access ends in FAULT with fault = 2'b10.
//   - Illegal opcodes end in FAULT with fault = 2'b01.
//   - FAULT is sticky until reset.
//
// Parameters
//   MEM_WAIT_EN  1: memory states stall on mem_ready; 0: mem_ready ignored
//   MEM_TIMEOUT  not-ready cycles allowed per access before FAULT (0 = off)
//   TMO_W        wait counter width, 2**TMO_W > MEM_TIMEOUT
//
// Ports
//   clk          core clock, rising edge
//   reset        synchronous, active-high
//   opcode       ir[31:26]
//   mem_ready    RAM finished the current read/write this cycle
//   pcWrite      unconditional PC load
//   pcWriteCond  branch PC load (qualified by zero in the datapath)
//   IorD         memory address select (0: PC, 1: ALUOut)
//   memRead      RAM read request
//   memWrite     RAM write request
//   IRwrite      IR load enable
//   MDRWrite     MDR load enable
//   ALUOutWrite  ALUOut load enable
//   pcSource     PC source (00: ALU, 01: ALUOut, 10: jump target)
//   aluSrcA      ALU A select (0: PC, 1: A)
//   aluSrcB      ALU B select (00: B, 01: 4, 10: imm, 11: imm<<2)
//   aluOp        ALU op (00: add, 01: sub, 10: funct)
//   regWrite     register file write
//   regDst       write register select (0: rt, 1: rd)
//   memtoReg     write-back data select (0: ALUOut, 1: MDR)
//   linkWrite    jal write of r31
//   fault        00: none, 01: illegal opcode, 10: memory timeout
//   state_dbg    current state encoding
// ----------------------------------------------------------------------------
module mc_control_fsm_v2 #(
    parameter int MEM_WAIT_EN = 1,
    parameter int MEM_TIMEOUT = 16,
    parameter int TMO_W       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       IorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       IRwrite,
    output logic       MDRWrite,
    output logic       ALUOutWrite,
    output logic [1:0] pcSource,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic       regWrite,
    output logic       regDst,
    output logic       memtoReg,
    output logic       linkWrite,
    output logic [1:0] fault,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JAL    = 4'd12,
        S_FAULT  = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_ILLEGAL = 2'b01;
    localparam logic [1:0] FLT_TIMEOUT = 2'b10;

    // Last counter value tolerated before the watchdog fires.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_t           r_state;
    logic [1:0]       r_fault;
    logic [TMO_W-1:0] r_wait_cnt;

    logic w_ready;
    logic w_mem_state;
    logic w_timeout;

    assign w_ready     = (MEM_WAIT_EN == 0) || mem_ready;
    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                         (r_state == S_MEMWR);
    // Fires on the not-ready cycle that would exceed the allowed wait.
    assign w_timeout   = (MEM_TIMEOUT > 0) && w_mem_state && !w_ready &&
                         (r_wait_cnt == TMO_LAST);

    // ------------------------------------------------------------------------
    // State, fault and wait counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_fault    <= FLT_NONE;
            r_wait_cnt <= '0;
        end else begin
            // Counter only runs while stalled; any ready cycle or exit clears it.
            if (w_mem_state && !w_ready && !w_timeout)
                r_wait_cnt <= r_wait_cnt + TMO_W'(1);
            else
                r_wait_cnt <= '0;

            if (w_timeout) begin
                r_state <= S_FAULT;
                r_fault <= FLT_TIMEOUT;
            end else begin
                case (r_state)
                    S_FETCH: begin
                        if (w_ready)
                            r_state <= S_DECODE;
                    end
                    S_DECODE: begin
                        case (opcode)
                            OP_LW, OP_SW:    r_state <= S_MEMADR;
                            OP_RTYPE:        r_state <= S_EXEC;
                            OP_BEQ, OP_BNE:  r_state <= S_BRANCH;
                            OP_ADDI:         r_state <= S_ADDIEX;
                            OP_J:            r_state <= S_JUMP;
                            OP_JAL:          r_state <= S_JAL;
                            default: begin
                                r_state <= S_FAULT;
                                r_fault <= FLT_ILLEGAL;
                            end
                        endcase
                    end
                    S_MEMADR: begin
                        if (opcode == OP_SW)
                            r_state <= S_MEMWR;
                        else
                            r_state <= S_MEMRD;
                    end
                    S_MEMRD: begin
                        if (w_ready)
                            r_state <= S_MEMWB;
                    end
                    S_MEMWR: begin
                        if (w_ready)
                            r_state <= S_FETCH;
                    end
                    S_EXEC:   r_state <= S_RWB;
                    S_ADDIEX: r_state <= S_ADDIWB;
                    S_MEMWB,
                    S_RWB,
                    S_BRANCH,
                    S_JUMP,
                    S_ADDIWB,
                    S_JAL:    r_state <= S_FETCH;
                    S_FAULT:  r_state <= S_FAULT;
                    // Unused encodings: restart instruction flow.
                    default:  r_state <= S_FETCH;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control decode. Combinational so the memory handshake qualifiers
    // (IRwrite, pcWrite, MDRWrite) act in the same cycle mem_ready arrives.
    // Reset masks everything so an in-flight RAM request drops immediately.
    // ------------------------------------------------------------------------
    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        IorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        IRwrite     = 1'b0;
        MDRWrite    = 1'b0;
        ALUOutWrite = 1'b0;
        pcSource    = 2'b00;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        aluOp       = 2'b00;
        regWrite    = 1'b0;
        regDst      = 1'b0;
        memtoReg    = 1'b0;
        linkWrite   = 1'b0;

        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    memRead = 1'b1;
                    if (w_ready) begin
                        IRwrite = 1'b1;
                        pcWrite = 1'b1;
                        aluSrcB = 2'b01;
                    end
                end
                S_DECODE: begin
                    aluSrcB     = 2'b11;
                    ALUOutWrite = 1'b1;
                end
                S_MEMADR: begin
                    aluSrcA     = 1'b1;
                    aluSrcB     = 2'b10;
                    ALUOutWrite = 1'b1;
                end
                S_MEMRD: begin
                    memRead = 1'b1;
                    IorD    = 1'b1;
                    if (w_ready)
                        MDRWrite = 1'b1;
                end
                S_MEMWB: begin
                    regWrite = 1'b1;
                    memtoReg = 1'b1;
                end
                S_MEMWR: begin
                    memWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXEC: begin
                    aluSrcA     = 1'b1;
                    aluOp       = 2'b10;
                    ALUOutWrite = 1'b1;
                end
                S_RWB: begin
                    regWrite = 1'b1;
                    regDst   = 1'b1;
                end
                S_BRANCH: begin
                    aluSrcA     = 1'b1;
                    aluOp       = 2'b01;
                    pcWriteCond = 1'b1;
                    pcSource    = 2'b01;
                end
                S_ADDIEX: begin
                    aluSrcA     = 1'b1;
                    aluSrcB     = 2'b10;
                    ALUOutWrite = 1'b1;
                end
                S_ADDIWB: begin
                    regWrite = 1'b1;
                end
                S_JUMP: begin
                    pcWrite  = 1'b1;
                    pcSource = 2'b10;
                end
                S_JAL: begin
                    pcWrite   = 1'b1;
                    pcSource  = 2'b10;
                    linkWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign fault     = r_fault;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_mc_control_fsm_v2.sv
module tb_mc_control_fsm_v2;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] JAL  = 6'b000011;
    localparam logic [5:0] ILL  = 6'b111111;

    localparam logic [3:0] FE = 4'd0,  DE = 4'd1,  MA = 4'd2,  MR = 4'd3;
    localparam logic [3:0] MB = 4'd4,  MW = 4'd5,  EX = 4'd6,  RW = 4'd7;
    localparam logic [3:0] BR = 4'd8,  JP = 4'd9,  AE = 4'd10, AW = 4'd11;
    localparam logic [3:0] JL = 4'd12, FT = 4'd15;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pcWrite, pcWriteCond, IorD, memRead, memWrite, IRwrite;
    logic       MDRWrite, ALUOutWrite, aluSrcA, regWrite, regDst, memtoReg, linkWrite;
    logic [1:0] pcSource, aluSrcB, aluOp, fault;
    logic [3:0] state_dbg;

    mc_control_fsm_v2 #(.MEM_WAIT_EN(1), .MEM_TIMEOUT(8), .TMO_W(5)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .IorD(IorD),
        .memRead(memRead), .memWrite(memWrite), .IRwrite(IRwrite),
        .MDRWrite(MDRWrite), .ALUOutWrite(ALUOutWrite), .pcSource(pcSource),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .regWrite(regWrite), .regDst(regDst), .memtoReg(memtoReg),
        .linkWrite(linkWrite), .fault(fault), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       rdy;
        logic [3:0] st;
        logic [1:0] flt;
    } vec_t;

    typedef struct {
        int          idx;
        logic [3:0]  st;
        logic [1:0]  flt;
        logic [18:0] ctl;
    } exp_t;

    vec_t vt[$];
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   row    = 0;

    // Control word order:
    // pcWrite pcWriteCond IorD memRead memWrite IRwrite MDRWrite ALUOutWrite
    // pcSource[2] aluSrcA aluSrcB[2] aluOp[2] regWrite regDst memtoReg linkWrite
    function automatic logic [18:0] exp_ctl(input logic [3:0] st, input logic rdy,
                                            input logic rst);
        logic pw, pwc, iord, mr, mw, irw, mdrw, aow, asa, rw, rd, m2r, lk;
        logic [1:0] ps, asb, aop;
        {pw, pwc, iord, mr, mw, irw, mdrw, aow, asa, rw, rd, m2r, lk} = '0;
        ps = 2'b00; asb = 2'b00; aop = 2'b00;
        if (!rst) begin
            case (st)
                FE: begin mr = 1; if (rdy) begin irw = 1; pw = 1; asb = 2'b01; end end
                DE: begin asb = 2'b11; aow = 1; end
                MA: begin asa = 1; asb = 2'b10; aow = 1; end
                MR: begin mr = 1; iord = 1; mdrw = rdy; end
                MB: begin rw = 1; m2r = 1; end
                MW: begin mw = 1; iord = 1; end
                EX: begin asa = 1; aop = 2'b10; aow = 1; end
                RW: begin rw = 1; rd = 1; end
                BR: begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
                AE: begin asa = 1; asb = 2'b10; aow = 1; end
                AW: begin rw = 1; end
                JP: begin pw = 1; ps = 2'b10; end
                JL: begin pw = 1; ps = 2'b10; lk = 1; end
                default: ;
            endcase
        end
        return {pw, pwc, iord, mr, mw, irw, mdrw, aow, ps, asa, asb, aop, rw, rd, m2r, lk};
    endfunction

    task automatic add(input logic rst, input logic [5:0] op, input logic rdy,
                       input logic [3:0] st, input logic [1:0] flt);
        vec_t v;
        v.rst = rst; v.op = op; v.rdy = rdy; v.st = st; v.flt = flt;
        vt.push_back(v);
    endtask

    // One cycle: drive just after the edge, queue what must be seen this cycle.
    task automatic step(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = v.rst;
        opcode    = v.op;
        mem_ready = v.rdy;
        e.idx = row;
        e.st  = v.st;
        e.flt = v.flt;
        e.ctl = exp_ctl(v.st, v.rdy, v.rst);
        sb_q.push_back(e);
        row++;
    endtask

    task automatic step5(input logic rst, input logic [5:0] op, input logic rdy,
                         input logic [3:0] st, input logic [1:0] flt);
        vec_t v;
        v.rst = rst; v.op = op; v.rdy = rdy; v.st = st; v.flt = flt;
        step(v);
    endtask

    exp_t        mon_e;
    logic [18:0] act_ctl;
    assign act_ctl = {pcWrite, pcWriteCond, IorD, memRead, memWrite, IRwrite, MDRWrite,
                      ALUOutWrite, pcSource, aluSrcA, aluSrcB, aluOp, regWrite, regDst,
                      memtoReg, linkWrite};

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (state_dbg !== mon_e.st || fault !== mon_e.flt || act_ctl !== mon_e.ctl) begin
                errors++;
                $display("FAIL row%0d: state %0d want %0d, fault %b want %b, ctrl %b want %b",
                         mon_e.idx, state_dbg, mon_e.st, fault, mon_e.flt, act_ctl, mon_e.ctl);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; opcode = RT; mem_ready = 1'b0;

        // reset state: outputs masked even though FETCH would request memory
        add(1, LW, 1, FE, 0);
        // lw, zero wait: 0,1,2,3,4,0
        add(0, LW, 1, FE, 0); add(0, LW, 1, DE, 0); add(0, LW, 1, MA, 0);
        add(0, LW, 1, MR, 0); add(0, LW, 1, MB, 0);
        // add with three not-ready fetch cycles
        add(0, RT, 0, FE, 0); add(0, RT, 0, FE, 0); add(0, RT, 0, FE, 0);
        add(0, RT, 1, FE, 0); add(0, RT, 1, DE, 0); add(0, RT, 1, EX, 0);
        add(0, RT, 1, RW, 0);
        // sw, zero wait
        add(0, SW, 1, FE, 0); add(0, SW, 1, DE, 0); add(0, SW, 1, MA, 0);
        add(0, SW, 1, MW, 0);
        // beq, bne, j, jal, addi
        add(0, BEQ, 1, FE, 0); add(0, BEQ, 1, DE, 0); add(0, BEQ, 1, BR, 0);
        add(0, BNE, 1, FE, 0); add(0, BNE, 1, DE, 0); add(0, BNE, 1, BR, 0);
        add(0, JMP, 1, FE, 0); add(0, JMP, 1, DE, 0); add(0, JMP, 1, JP, 0);
        add(0, JAL, 1, FE, 0); add(0, JAL, 1, DE, 0); add(0, JAL, 1, JL, 0);
        add(0, ADDI, 1, FE, 0); add(0, ADDI, 1, DE, 0); add(0, ADDI, 1, AE, 0);
        add(0, ADDI, 1, AW, 0);
        // lw with two read wait cycles
        add(0, LW, 1, FE, 0); add(0, LW, 1, DE, 0); add(0, LW, 1, MA, 0);
        add(0, LW, 0, MR, 0); add(0, LW, 0, MR, 0); add(0, LW, 1, MR, 0);
        add(0, LW, 1, MB, 0);
        // sw with one write wait cycle
        add(0, SW, 1, FE, 0); add(0, SW, 1, DE, 0); add(0, SW, 1, MA, 0);
        add(0, SW, 0, MW, 0); add(0, SW, 1, MW, 0);
        // reset on the second read wait cycle drops memRead, no MDRWrite after
        add(0, LW, 1, FE, 0); add(0, LW, 1, DE, 0); add(0, LW, 1, MA, 0);
        add(0, LW, 0, MR, 0); add(1, LW, 0, MR, 0); add(0, LW, 1, FE, 0);

        repeat (2) @(posedge clk);
        foreach (vt[i]) step(vt[i]);

        // illegal opcode: sticky FAULT for 20 cycles, then reset recovers
        step5(0, ILL, 1, DE, 0);
        for (int k = 0; k < 20; k++)
            step5(0, (k % 2 == 0) ? LW : RT, k[0], FT, 2'b01);
        step5(1, RT, 1, FT, 2'b01);
        step5(0, SW, 1, FE, 0);

        // sw with RAM never ready: 8 write cycles, then timeout FAULT
        step5(0, SW, 1, DE, 0);
        step5(0, SW, 1, MA, 0);
        for (int k = 0; k < 8; k++) step5(0, SW, 0, MW, 0);
        step5(0, SW, 0, FT, 2'b10);
        step5(0, SW, 1, FT, 2'b10);
        step5(0, SW, 1, FT, 2'b10);
        step5(1, SW, 0, FT, 2'b10);

        // fetch watchdog, and a fetch that is ready on its last allowed cycle
        for (int k = 0; k < 7; k++) step5(0, RT, 0, FE, 0);
        step5(0, RT, 1, FE, 0);
        step5(0, RT, 1, DE, 0);
        step5(0, RT, 1, EX, 0);
        step5(0, RT, 1, RW, 0);
        for (int k = 0; k < 8; k++) step5(0, RT, 0, FE, 0);
        step5(0, RT, 1, FT, 2'b10);
        step5(1, RT, 0, FT, 2'b10);
        step5(0, RT, 0, FE, 0);

        @(posedge clk);
        @(posedge clk);
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
